// File: rtl/delay_meter_pkg.sv
// Shared types and constants for the delay meter.
// Default counter width and the FSM state encoding.
package delay_meter_pkg;

    localparam int CNT_W_DFLT = 16;
    localparam logic [CNT_W_DFLT-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPORT
    } state_t;

endpackage

// File: rtl/delay_meter_edge_sampler.sv
// Input sampler for the delay meter.
// Registers stimulus, y and valid and flags their edges.
module edge_sampler (
    input  logic       clk,
    input  logic [3:0] abcd,
    input  logic       y,
    input  logic       valid,
    output logic       vchg,
    output logic       ytog,
    output logic       vfall
);

    logic [3:0] abcd_q;
    logic       y_q;
    logic       valid_q;

    // previous-cycle copies; loading every cycle means reset leaves no stale edge
    always_ff @(posedge clk) begin
        abcd_q  <= abcd;
        y_q     <= y;
        valid_q <= valid;
    end

    assign vchg  = (abcd != abcd_q);
    assign ytog  = (y != y_q);
    assign vfall = valid_q & ~valid;

endmodule

// File: rtl/delay_meter.sv
// Measures stimulus-to-output delay in clk cycles.
// One result per window plus worst-case rise/fall statistics.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             y,
    input  logic             valid,
    input  logic             stats_clr,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_tpd,
    output logic [CNT_W-1:0] res_tcd,
    output logic             res_rise,
    output logic             res_noedge,
    output logic             res_sat,
    output logic [CNT_W-1:0] max_tpd_r,
    output logic [CNT_W-1:0] max_tpd_f,
    output logic [CNT_W-1:0] min_tcd_r,
    output logic [CNT_W-1:0] min_tcd_f,
    output logic             overlap_err
);

    localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state, state_nx;

    logic             vchg, ytog, vfall;
    logic [CNT_W-1:0] cnt, tpd, tcd;
    logic [CNT_W-1:0] tpd_nx, tcd_nx;
    logic             seen, sat;
    logic             seen_nx, sat_nx, cnt_top;

    edge_sampler u_es (
        .clk   (clk),
        .abcd  ({a, b, c, d}),
        .y     (y),
        .valid (valid),
        .vchg  (vchg),
        .ytog  (ytog),
        .vfall (vfall)
    );

    // window values including a toggle in the current cycle
    assign cnt_top   = (cnt == MAXV);
    assign seen_nx   = seen | ytog;
    assign sat_nx    = sat | cnt_top;
    assign tpd_nx    = ytog ? cnt : tpd;
    assign tcd_nx    = (ytog && !seen) ? cnt : tcd;
    assign res_valid = (state == REPORT);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (vchg) state_nx = RUN;
            RUN:     if (vfall) state_nx = REPORT;
            REPORT:  state_nx = vchg ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // window counter, toggle capture and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            tpd         <= '0;
            tcd         <= '0;
            seen        <= 1'b0;
            sat         <= 1'b0;
            res_tpd     <= '0;
            res_tcd     <= '0;
            res_rise    <= 1'b0;
            res_noedge  <= 1'b0;
            res_sat     <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE, REPORT: begin
                    if (vchg) begin
                        cnt  <= ONE;
                        seen <= ytog;
                        sat  <= 1'b0;
                        tpd  <= '0;
                        tcd  <= '0;
                    end
                end
                RUN: begin
                    if (vfall) begin
                        res_tpd    <= seen_nx ? tpd_nx : '0;
                        res_tcd    <= seen_nx ? tcd_nx : '0;
                        res_rise   <= y;
                        res_noedge <= ~seen_nx;
                        res_sat    <= sat_nx;
                    end else if (vchg) begin
                        overlap_err <= 1'b1;
                        cnt         <= ONE;
                        seen        <= ytog;
                        sat         <= 1'b0;
                        tpd         <= '0;
                        tcd         <= '0;
                    end else begin
                        cnt  <= cnt_top ? cnt : cnt + ONE;
                        sat  <= sat_nx;
                        seen <= seen_nx;
                        tpd  <= tpd_nx;
                        tcd  <= tcd_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // worst-case statistics, clear wins over a same-cycle report
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            max_tpd_r <= '0;
            max_tpd_f <= '0;
            min_tcd_r <= MAXV;
            min_tcd_f <= MAXV;
        end else if (state == REPORT && !res_noedge) begin
            if (res_rise) begin
                if (res_tpd > max_tpd_r) max_tpd_r <= res_tpd;
                if (res_tcd < min_tcd_r) min_tcd_r <= res_tcd;
            end else begin
                if (res_tpd > max_tpd_f) max_tpd_f <= res_tpd;
                if (res_tcd < min_tcd_f) min_tcd_f <= res_tcd;
            end
        end
    end

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter at 16-bit and 4-bit counter widths.
// Both instances share stimulus and are checked against a window model.
module tb_delay_meter;

    logic clk = 1'b0;
    logic rst, a, b, c, d, y, valid, stats_clr;

    logic        rv16, rise16, noe16, sat16, ovl16;
    logic [15:0] tpd16, tcd16, maxr16, maxf16, minr16, minf16;
    logic        rv4, rise4, noe4, sat4, ovl4;
    logic [3:0]  tpd4, tcd4, maxr4, maxf4, minr4, minf4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_meter #(.CNT_W(16)) u16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .y(y),
        .valid(valid), .stats_clr(stats_clr),
        .res_valid(rv16), .res_tpd(tpd16), .res_tcd(tcd16),
        .res_rise(rise16), .res_noedge(noe16), .res_sat(sat16),
        .max_tpd_r(maxr16), .max_tpd_f(maxf16),
        .min_tcd_r(minr16), .min_tcd_f(minf16),
        .overlap_err(ovl16)
    );

    delay_meter #(.CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .y(y),
        .valid(valid), .stats_clr(stats_clr),
        .res_valid(rv4), .res_tpd(tpd4), .res_tcd(tcd4),
        .res_rise(rise4), .res_noedge(noe4), .res_sat(sat4),
        .max_tpd_r(maxr4), .max_tpd_f(maxf4),
        .min_tcd_r(minr4), .min_tcd_f(minf4),
        .overlap_err(ovl4)
    );

    // model state: a window is an open time plus first/last toggle offsets
    int         wid [2] = '{16, 4};
    bit         m_open, m_pend, m_ovl;
    int         m_start, m_first, m_last, cyc;
    logic [3:0] p_abcd;
    logic       p_y, p_valid;
    bit         e_rise, e_noedge;
    int         e_tpd [2], e_tcd [2], e_sat [2];
    int         e_maxr [2], e_maxf [2], e_minr [2], e_minf [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int mx(input int i);
        return (1 << wid[i]) - 1;
    endfunction

    function automatic int lim(input int v, input int i);
        return (v > mx(i)) ? mx(i) : v;
    endfunction

    task automatic open_win(input bit yt);
        m_open  = 1;
        m_start = cyc;
        m_first = yt ? 0 : -1;
        m_last  = m_first;
    endtask

    task automatic model_step(input logic [3:0] v, input logic yy,
                              input logic vv, input logic clr,
                              input logic rr);
        bit vc, yt, vf;
        int k;
        vc = (v != p_abcd);
        yt = (yy != p_y);
        vf = p_valid & ~vv;
        if (rr) begin
            m_open = 0; m_pend = 0; m_ovl = 0;
            e_rise = 0; e_noedge = 0;
            for (int i = 0; i < 2; i++) begin
                e_tpd[i] = 0; e_tcd[i] = 0; e_sat[i] = 0;
                e_maxr[i] = 0; e_maxf[i] = 0;
                e_minr[i] = mx(i); e_minf[i] = mx(i);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clr) begin
                    e_maxr[i] = 0; e_maxf[i] = 0;
                    e_minr[i] = mx(i); e_minf[i] = mx(i);
                end else if (m_pend && !e_noedge) begin
                    if (e_rise) begin
                        if (e_tpd[i] > e_maxr[i]) e_maxr[i] = e_tpd[i];
                        if (e_tcd[i] < e_minr[i]) e_minr[i] = e_tcd[i];
                    end else begin
                        if (e_tpd[i] > e_maxf[i]) e_maxf[i] = e_tpd[i];
                        if (e_tcd[i] < e_minf[i]) e_minf[i] = e_tcd[i];
                    end
                end
            end
            m_pend = 0;
            if (!m_open) begin
                if (vc) open_win(yt);
            end else begin
                k = cyc - m_start;
                if (yt) begin
                    if (m_first < 0) m_first = k;
                    m_last = k;
                end
                if (vf) begin
                    m_open   = 0;
                    m_pend   = 1;
                    e_rise   = yy;
                    e_noedge = (m_first < 0);
                    for (int i = 0; i < 2; i++) begin
                        e_tcd[i] = e_noedge ? 0 : lim(m_first, i);
                        e_tpd[i] = e_noedge ? 0 : lim(m_last, i);
                        e_sat[i] = (k >= mx(i)) ? 1 : 0;
                    end
                end else if (vc) begin
                    m_ovl = 1;
                    open_win(yt);
                end
            end
        end
        p_abcd  = v;
        p_y     = yy;
        p_valid = vv;
        cyc++;
    endtask

    task automatic check_all();
        chk("rv16", rv16, m_pend);
        chk("rv4", rv4, m_pend);
        chk("ovl16", ovl16, m_ovl);
        chk("ovl4", ovl4, m_ovl);
        chk("maxr16", maxr16, e_maxr[0]);
        chk("maxf16", maxf16, e_maxf[0]);
        chk("minr16", minr16, e_minr[0]);
        chk("minf16", minf16, e_minf[0]);
        chk("maxr4", maxr4, e_maxr[1]);
        chk("maxf4", maxf4, e_maxf[1]);
        chk("minr4", minr4, e_minr[1]);
        chk("minf4", minf4, e_minf[1]);
        if (m_pend) begin
            chk("tpd16", tpd16, e_tpd[0]);
            chk("tcd16", tcd16, e_tcd[0]);
            chk("sat16", sat16, e_sat[0]);
            chk("tpd4", tpd4, e_tpd[1]);
            chk("tcd4", tcd4, e_tcd[1]);
            chk("sat4", sat4, e_sat[1]);
            chk("rise16", rise16, e_rise);
            chk("rise4", rise4, e_rise);
            chk("noe16", noe16, e_noedge);
            chk("noe4", noe4, e_noedge);
        end
    endtask

    task automatic tick(input logic [3:0] v, input logic yy, input logic vv,
                        input logic clr, input logic rr);
        {a, b, c, d} = v;
        y         = yy;
        valid     = vv;
        stats_clr = clr;
        rst       = rr;
        model_step(v, yy, vv, clr, rr);
        @(negedge clk);
        check_all();
    endtask

    // window: stimulus v at offset 0, y toggles at set mask bits, valid
    // falls at offset cl, then the report cycle with optional stats clear
    task automatic run_win(input logic [3:0] v, input logic [63:0] tm,
                           input int cl, input logic clr_rep);
        logic yy;
        yy = y;
        for (int k = 0; k <= cl; k++) begin
            if (tm[k]) yy = ~yy;
            tick(v, yy, (k == cl) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        end
        tick(v, yy, 1'b0, clr_rep, 1'b0);
    endtask

    initial begin
        logic [3:0] rv;
        logic       ry, rvl;
        {a, b, c, d} = 4'b0000;
        y = 0; valid = 0; stats_clr = 0; rst = 1;
        p_abcd = 4'b0000; p_y = 0; p_valid = 0; cyc = 0;

        tick(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_minr16", minr16, 16'hFFFF);
        chk("t1_maxr16", maxr16, 16'h0000);
        chk("t1_minf4", minf4, 4'hF);

        run_win(4'b1010, 64'h68, 12, 1'b0);
        chk("t2_tcd", tcd16, 3);
        chk("t2_tpd", tpd16, 6);
        chk("t2_rise", rise16, 1);
        chk("t2_maxr", maxr16, 6);
        chk("t2_minr", minr16, 3);

        run_win(4'b0000, 64'h10, 8, 1'b0);
        chk("t3_tpd", tpd16, 4);
        chk("t3_rise", rise16, 0);
        chk("t3_minf", minf16, 4);
        chk("t3_maxr", maxr16, 6);

        run_win(4'b1111, 64'h0, 6, 1'b0);
        chk("t4_noedge", noe16, 1);
        chk("t4_tpd", tpd16, 0);
        chk("t4_maxf", maxf16, 4);

        tick(4'b0001, y, 1'b1, 1'b0, 1'b0);
        tick(4'b0001, y, 1'b1, 1'b0, 1'b0);
        tick(4'b0011, y, 1'b1, 1'b0, 1'b0);
        tick(4'b0011, y, 1'b1, 1'b0, 1'b0);
        tick(4'b0011, y, 1'b1, 1'b0, 1'b0);
        tick(4'b0011, ~y, 1'b1, 1'b0, 1'b0);
        tick(4'b0011, y, 1'b1, 1'b0, 1'b0);
        tick(4'b0011, y, 1'b0, 1'b0, 1'b0);
        tick(4'b0011, y, 1'b0, 1'b0, 1'b0);
        chk("t5_ovl", ovl16, 1);
        chk("t5_tcd", tcd16, 3);

        run_win(4'b0101, 64'h100000, 22, 1'b0);
        chk("t6_sat4", sat4, 1);
        chk("t6_tpd4", tpd4, 15);
        chk("t6_tpd16", tpd16, 20);
        chk("t6_sat16", sat16, 0);

        run_win(4'b1001, 64'h4, 5, 1'b1);
        chk("t7_maxr", maxr16, 0);
        chk("t7_minf", minf16, 16'hFFFF);

        tick(4'b0110, y, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(4'b0110, ~y, 1'b1, 1'b0, 1'b0);
        tick(4'b0110, y, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(4'b0110, y, 1'b0, 1'b0, 1'b0);
            chk("t8_rv", rv16, 0);
        end

        rv = 4'b0110; ry = y; rvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rv = 4'($urandom);
            if ($urandom_range(0, 3) == 0) ry = ~ry;
            if ($urandom_range(0, 9) == 0) rvl = ~rvl;
            tick(rv, ry, rvl, ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
